// File: rtl/uart_echo_sched_pkg.sv
// Shared definitions for the UART echo scheduler: register map, status bit
// positions, scheduler state encoding and round-robin side encoding.
package uart_echo_sched_pkg;

  // Register addresses presented on the shared bus to both UART halves
  localparam logic [2:0] TXREG     = 3'd0;
  localparam logic [2:0] CONTROLTX = 3'd1;
  localparam logic [2:0] RXREG     = 3'd2;
  localparam logic [2:0] CONTROLRX = 3'd3;

  // Status bit positions in the control-register read data
  localparam int RX_READY_BIT = 1;
  localparam int TX_BUSY_BIT  = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARM,
    S_ARB,
    S_RX_POLL,
    S_RX_PW,
    S_RX_RD,
    S_RX_RW,
    S_TX_POLL,
    S_TX_PW,
    S_TX_LD,
    S_TX_GO
  } state_t;

  // Side that the arbiter prefers on the next contested grant
  typedef enum logic {
    RR_RX = 1'b0,
    RR_TX = 1'b1
  } rr_t;

endpackage

// File: rtl/uart_echo_sched_if.sv
// Register bus shared by uart_rx and uart_tx. The scheduler is the master;
// the two UART halves together form the slave side.
interface uart_echo_sched_if;
  logic [2:0] addr;
  logic       wr_rx;
  logic       rd_rx;
  logic       wr_tx;
  logic       rd_tx;
  logic [7:0] wdata;
  logic [7:0] rx_rdata;
  logic [7:0] tx_rdata;

  modport master (
    output addr, wr_rx, rd_rx, wr_tx, rd_tx, wdata,
    input  rx_rdata, tx_rdata
  );

  modport slave (
    input  addr, wr_rx, rd_rx, wr_tx, rd_tx, wdata,
    output rx_rdata, tx_rdata
  );
endinterface

// File: rtl/uart_echo_sched_fifo.sv
// echo_fifo: small synchronous byte FIFO buffering received bytes until the
// transmitter can take them. Head data is presented combinationally on dout.
module echo_fifo #(
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [7:0]   din,
  output logic [7:0]   dout,
  output logic [AW:0]  level,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 2 ** AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

  // Storage array; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally mod depth; level tracks occupancy separately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      if ((push && !full) && !(pop && !empty))      level <= level + 1'b1;
      else if ((pop && !empty) && !(push && !full)) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/uart_echo_sched.sv
// uart_echo_sched: owns the shared register bus of one uart_rx and one
// uart_tx. Arms and polls the receiver, buffers bytes in echo_fifo, and
// drains them to the transmitter, alternating service between the two sides.
module uart_echo_sched
  import uart_echo_sched_pkg::*;
#(
  parameter int         FIFO_AW = 2,
  parameter logic [7:0] ARM_VAL = 8'h01,
  parameter logic [7:0] GO_VAL  = 8'h01
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 echo_en,
  uart_echo_sched_if.master    bus,
  output logic [FIFO_AW:0]     fifo_level,
  output logic                 busy,
  output logic [7:0]           rx_count,
  output logic [7:0]           tx_count
);

  state_t     state;
  rr_t        rr;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_push;
  logic       fifo_pop;
  logic       rx_ok;
  logic       tx_ok;
  logic       grant_rx;
  logic       grant_tx;

  // Push and pop live in distinct states, so they can never coincide
  assign fifo_push = (state == S_RX_RW);
  assign fifo_pop  = (state == S_TX_GO);

  echo_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.rx_rdata),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A side is eligible only if serving it cannot overflow/underflow the FIFO;
  // a contested grant goes to the side not served last.
  assign rx_ok    = !fifo_full;
  assign tx_ok    = !fifo_empty;
  assign grant_rx = rx_ok && (!tx_ok || rr == RR_RX);
  assign grant_tx = tx_ok && (!rx_ok || rr == RR_TX);

  assign busy = (state != S_IDLE);

  // Scheduler FSM; strobes, addr and wdata are registered on entry to the
  // state that owns them so they change together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      rr         <= RR_RX;
      bus.addr   <= TXREG;
      bus.wdata  <= '0;
      bus.wr_rx  <= 1'b0;
      bus.rd_rx  <= 1'b0;
      bus.wr_tx  <= 1'b0;
      bus.rd_tx  <= 1'b0;
      rx_count   <= '0;
      tx_count   <= '0;
    end else begin
      bus.wr_rx <= 1'b0;
      bus.rd_rx <= 1'b0;
      bus.wr_tx <= 1'b0;
      bus.rd_tx <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (echo_en) begin
            state     <= S_ARM;
            bus.wr_rx <= 1'b1;
            bus.addr  <= CONTROLRX;
            bus.wdata <= ARM_VAL;
          end
        end
        S_ARM: state <= S_ARB;
        S_ARB: begin
          if (!echo_en) begin
            state <= S_IDLE;
          end else if (grant_rx) begin
            state     <= S_RX_POLL;
            bus.rd_rx <= 1'b1;
            bus.addr  <= CONTROLRX;
          end else if (grant_tx) begin
            state     <= S_TX_POLL;
            bus.rd_tx <= 1'b1;
            bus.addr  <= CONTROLTX;
          end
        end
        S_RX_POLL: state <= S_RX_PW;
        S_RX_PW: begin
          rr <= RR_TX;
          if (bus.rx_rdata[RX_READY_BIT]) begin
            state     <= S_RX_RD;
            bus.rd_rx <= 1'b1;
            bus.addr  <= RXREG;
          end else begin
            state <= S_ARB;
          end
        end
        S_RX_RD: state <= S_RX_RW;
        S_RX_RW: begin
          // Byte is pushed this cycle; the receiver must be re-armed
          rx_count  <= rx_count + 8'd1;
          state     <= S_ARM;
          bus.wr_rx <= 1'b1;
          bus.addr  <= CONTROLRX;
          bus.wdata <= ARM_VAL;
        end
        S_TX_POLL: state <= S_TX_PW;
        S_TX_PW: begin
          rr <= RR_RX;
          if (bus.tx_rdata[TX_BUSY_BIT]) begin
            state <= S_ARB;
          end else begin
            state     <= S_TX_LD;
            bus.wr_tx <= 1'b1;
            bus.addr  <= TXREG;
            bus.wdata <= fifo_dout;
          end
        end
        S_TX_LD: begin
          state     <= S_TX_GO;
          bus.wr_tx <= 1'b1;
          bus.addr  <= CONTROLTX;
          bus.wdata <= GO_VAL;
        end
        S_TX_GO: begin
          tx_count <= tx_count + 8'd1;
          state    <= S_ARB;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_sched.sv
// Bench for uart_echo_sched: behavioural far-end UART models on the bus, a
// transaction-level expectation of FIFO contents and counters, and directed
// scenarios pinned with hand-computed values.
module tb_uart_echo_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       echo_en = 1'b0;
  logic [2:0] fifo_level;
  logic       busy;
  logic [7:0] rx_count;
  logic [7:0] tx_count;

  uart_echo_sched_if bus();

  uart_echo_sched #(.FIFO_AW(2), .ARM_VAL(8'h01), .GO_VAL(8'h01)) dut (
    .clk        (clk),
    .reset      (reset),
    .echo_en    (echo_en),
    .bus        (bus),
    .fifo_level (fifo_level),
    .busy       (busy),
    .rx_count   (rx_count),
    .tx_count   (tx_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // far-end and expectation state
  byte unsigned src_q[$];      // bytes the far-end receiver will deliver
  byte unsigned fifo_m[$];     // bytes expected in the DUT FIFO
  byte unsigned sent_log[$];   // bytes launched by GO writes
  byte unsigned fed_log[$];    // bytes offered to the receiver
  int           ev_log[$];     // writes and data reads, encoded
  int           grant_log[$];  // 0 = RX poll, 1 = TX poll
  bit           armed, rx_seen_ready, tx_poll_idle, ld_prev;
  int           rx_pushed, sent_total, tx_busy_cnt, last_side, max_level;
  bit           tx_hold = 1'b0;
  bit           rx_jitter = 1'b0;
  int           tx_busy_max = 0;
  logic [7:0]   tx_hold_reg;
  bit           rx_pend_v, rx_pend_data, tx_pend_v;
  logic [7:0]   rx_pend, tx_pend;
  bit           do_push, rdy, tbusy;
  logic [7:0]   push_b, b;
  int           fed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ev(input int t, input int a, input int d);
    return t * 65536 + a * 256 + d;
  endfunction

  task automatic wait_sent(input int n, input int budget);
    int k;
    k = 0;
    while (sent_total < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_sent_timeout", sent_total >= n, 1);
  endtask

  // Far-end UART models plus per-cycle comparison against the expectation
  initial begin
    bus.rx_rdata = '0;
    bus.tx_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        src_q.delete(); fifo_m.delete(); sent_log.delete();
        ev_log.delete(); grant_log.delete();
        armed = 0; rx_seen_ready = 0; tx_poll_idle = 0; ld_prev = 0;
        rx_pushed = 0; sent_total = 0; tx_busy_cnt = 0; last_side = 1;
        max_level = 0; rx_pend_v = 0; tx_pend_v = 0; rx_pend_data = 0;
        bus.rx_rdata = 8'($urandom);
        bus.tx_rdata = 8'($urandom);
      end else begin
        // read data is valid only in the cycle after the read strobe
        do_push = rx_pend_v && rx_pend_data;
        push_b = rx_pend;
        bus.rx_rdata = rx_pend_v ? rx_pend : 8'($urandom);
        bus.tx_rdata = tx_pend_v ? tx_pend : 8'($urandom);
        rx_pend_v = 0;
        tx_pend_v = 0;

        chk("level", fifo_level, fifo_m.size());
        chk("rx_count", rx_count, rx_pushed % 256);
        chk("tx_count", tx_count, sent_total % 256);
        chk("one_strobe", $countones({bus.wr_rx, bus.rd_rx, bus.wr_tx, bus.rd_tx}) <= 1, 1);
        if (bus.wr_rx || bus.rd_rx || bus.wr_tx || bus.rd_tx) chk("busy_on_strobe", busy, 1);
        if (int'(fifo_level) > max_level) max_level = fifo_level;

        if (do_push) begin
          fifo_m.push_back(push_b);
          rx_pushed++;
        end
        if (tx_busy_cnt > 0) tx_busy_cnt--;

        if (bus.wr_rx) begin
          chk("arm_addr", bus.addr, 3);
          chk("arm_data", bus.wdata, 8'h01);
          armed = 1;
          ev_log.push_back(ev(1, bus.addr, bus.wdata));
        end
        if (bus.rd_rx) begin
          if (bus.addr == 3'd3) begin
            chk("rx_poll_not_full", fifo_m.size() < 4, 1);
            if (last_side == 0) chk("rr_rx_repeat_needs_empty", fifo_m.size(), 0);
            last_side = 0;
            grant_log.push_back(0);
            rdy = armed && (src_q.size() > 0) && (!rx_jitter || $urandom_range(0, 3) != 0);
            rx_seen_ready = rdy;
            rx_pend = 8'($urandom);
            rx_pend[1] = rdy;
            rx_pend_v = 1;
            rx_pend_data = 0;
          end else if (bus.addr == 3'd2) begin
            chk("rx_read_after_ready", armed && rx_seen_ready, 1);
            b = (src_q.size() > 0) ? src_q.pop_front() : 8'($urandom);
            rx_pend = b;
            rx_pend_v = 1;
            rx_pend_data = 1;
            armed = 0;
            rx_seen_ready = 0;
            ev_log.push_back(ev(2, 2, b));
          end else begin
            chk("rd_rx_addr", bus.addr, 3);
          end
        end
        if (bus.rd_tx) begin
          chk("tx_poll_addr", bus.addr, 1);
          chk("tx_poll_not_empty", fifo_m.size() > 0, 1);
          if (last_side == 1) chk("rr_tx_repeat_needs_full", fifo_m.size(), 4);
          last_side = 1;
          grant_log.push_back(1);
          tbusy = tx_hold || (tx_busy_cnt > 0);
          tx_pend = 8'($urandom);
          tx_pend[0] = tbusy;
          tx_pend_v = 1;
          tx_poll_idle = !tbusy;
        end
        if (bus.wr_tx) begin
          if (bus.addr == 3'd0) begin
            chk("ld_after_idle_poll", tx_poll_idle, 1);
            chk("ld_data", bus.wdata, (fifo_m.size() > 0) ? 32'(fifo_m[0]) : 32'h100);
            tx_hold_reg = bus.wdata;
            ev_log.push_back(ev(3, 0, bus.wdata));
          end else if (bus.addr == 3'd1) begin
            chk("go_after_ld", ld_prev, 1);
            chk("go_data", bus.wdata, 8'h01);
            chk("go_tx_idle", tx_hold || (tx_busy_cnt > 0), 0);
            chk("echo_byte", tx_hold_reg, (fifo_m.size() > 0) ? 32'(fifo_m[0]) : 32'h100);
            if (fifo_m.size() > 0) void'(fifo_m.pop_front());
            sent_log.push_back(tx_hold_reg);
            sent_total++;
            tx_busy_cnt = $urandom_range(0, tx_busy_max);
            tx_poll_idle = 0;
            ev_log.push_back(ev(3, 1, bus.wdata));
          end else begin
            chk("wr_tx_addr", bus.addr, 0);
          end
        end
        ld_prev = bus.wr_tx && (bus.addr == 3'd0);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Directed scenarios
  initial begin
    int k, viol, sz, rem, mm;
    bit found;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    #1;
    chk("rst_strobes", {bus.wr_rx, bus.rd_rx, bus.wr_tx, bus.rd_tx}, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_tx_count", tx_count, 0);

    // ---- 1: reset mid-S_TX_LD ----
    reset = 1'b1;
    echo_en = 1'b1;
    tx_busy_max = 3;
    src_q.push_back(8'h55);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      #1;
      if (bus.wr_tx && bus.addr == 3'd0) found = 1;
    end
    chk("t1_reach_ld", found, 1);
    chk("t1_level_before", fifo_level, 1);
    reset = 1'b0;
    #1;
    chk("t1_strobes", {bus.wr_rx, bus.rd_rx, bus.wr_tx, bus.rd_tx}, 0);
    chk("t1_level", fifo_level, 0);
    chk("t1_busy", busy, 0);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;

    // ---- 2: single byte echo ----
    src_q.push_back(8'h41);
    fed_log.push_back(8'h41);
    fed = 1;
    wait_sent(fed, 300);
    repeat (10) @(negedge clk);
    #1;
    chk("t2_ev_count", ev_log.size(), 5);
    chk("t2_ev0", (ev_log.size() > 0) ? ev_log[0] : -1, ev(1, 3, 8'h01));
    chk("t2_ev1", (ev_log.size() > 1) ? ev_log[1] : -1, ev(2, 2, 8'h41));
    chk("t2_ev2", (ev_log.size() > 2) ? ev_log[2] : -1, ev(1, 3, 8'h01));
    chk("t2_ev3", (ev_log.size() > 3) ? ev_log[3] : -1, ev(3, 0, 8'h41));
    chk("t2_ev4", (ev_log.size() > 4) ? ev_log[4] : -1, ev(3, 1, 8'h01));
    chk("t2_rx_count", rx_count, 1);
    chk("t2_tx_count", tx_count, 1);

    // ---- 3: TX held busy, FIFO fills, then drains in order ----
    tx_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src_q.push_back(8'(8'h10 + i));
      fed_log.push_back(8'(8'h10 + i));
    end
    fed += 4;
    k = 0;
    while (fifo_m.size() < 4 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("t3_fill_timeout", fifo_m.size(), 4);
    repeat (40) @(negedge clk);
    #1;
    chk("t3_level_full", fifo_level, 4);
    tx_hold = 1'b0;
    wait_sent(fed, 500);
    #1;
    chk("t3_order0", (sent_log.size() > 1) ? sent_log[1] : 0, 8'h10);
    chk("t3_order1", (sent_log.size() > 2) ? sent_log[2] : 0, 8'h11);
    chk("t3_order2", (sent_log.size() > 3) ? sent_log[3] : 0, 8'h12);
    chk("t3_order3", (sent_log.size() > 4) ? sent_log[4] : 0, 8'h13);

    // ---- 4: RX always ready, TX always idle -> strict alternation ----
    tx_busy_max = 0;
    for (int i = 0; i < 30; i++) begin
      b = 8'($urandom);
      src_q.push_back(b);
      fed_log.push_back(b);
    end
    fed += 30;
    repeat (12) @(negedge clk);
    #1;
    grant_log.delete();
    max_level = 0;
    repeat (66) @(negedge clk);
    #1;
    viol = 0;
    for (int i = 1; i < grant_log.size(); i++)
      if (grant_log[i] == grant_log[i-1]) viol++;
    chk("t4_alternation", viol, 0);
    chk("t4_enough_grants", grant_log.size() >= 8, 1);
    chk("t4_max_level", max_level <= 1, 1);
    tx_busy_max = 6;
    wait_sent(fed, 3000);

    // ---- 5: echo_en dropped during S_RX_RD ----
    src_q.push_back(8'h5A);
    fed_log.push_back(8'h5A);
    fed += 1;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      #1;
      if (bus.rd_rx && bus.addr == 3'd2) found = 1;
    end
    chk("t5_reach_rd", found, 1);
    echo_en = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    sz = ev_log.size();
    chk("t5_busy", busy, 0);
    chk("t5_level", fifo_level, 1);
    chk("t5_rx_count", rx_count, fed % 256);
    chk("t5_tx_count", tx_count, (fed - 1) % 256);
    chk("t5_last_rearm", (sz >= 1) ? ev_log[sz-1] : -1, ev(1, 3, 8'h01));
    chk("t5_prev_read", (sz >= 2) ? ev_log[sz-2] : -1, ev(2, 2, 8'h5A));
    echo_en = 1'b1;
    wait_sent(fed, 500);

    // ---- 6: random traffic up to 256 bytes total, counters wrap ----
    rx_jitter = 1'b1;
    tx_busy_max = 12;
    rem = 256 - fed;
    for (int i = 0; i < rem; i++) begin
      b = 8'($urandom);
      src_q.push_back(b);
      fed_log.push_back(b);
      fed++;
      repeat ($urandom_range(0, 25)) @(negedge clk);
      #1;
      if ($urandom_range(0, 19) == 0) begin
        echo_en = 1'b0;
        repeat ($urandom_range(1, 30)) @(negedge clk);
        #1;
        echo_en = 1'b1;
      end
    end
    wait_sent(256, 30000);
    repeat (20) @(negedge clk);
    #1;
    chk("t6_rx_wrap", rx_count, 0);
    chk("t6_tx_wrap", tx_count, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_sent_total", sent_total, 256);
    mm = 0;
    for (int i = 0; i < 256; i++) begin
      if (i >= sent_log.size() || i >= fed_log.size()) mm++;
      else if (sent_log[i] != fed_log[i]) mm++;
    end
    chk("t6_stream", mm, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
